// File: rtl/ifetch_unit.sv
// ============================================================================
//  Module      : ifetch_unit
//  Description : PC register and instruction-fetch sequencer. Fetches one
//                word from a variable-latency instruction memory, holds it
//                for an execute cycle, then registers the next PC chosen
//                by the controller. Traps misaligned targets and counts
//                retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_unit #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  // instruction memory
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  // controller / datapath
  input  logic            pc_source1,
  input  logic            pc_source2,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_result,
  input  logic            hold,
  // decoded instruction
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [2:0]      f3,
  output logic [6:0]      f7,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  // trap and statistics
  output logic            misaligned,
  output logic [XLEN-1:0] bad_addr,
  output logic [31:0]     instret
);

  localparam logic [31:0] c_nop = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_jalr_target;
  logic            w_next_aligned;

  // Decoded fields are plain slices of the held instruction word.
  assign op        = instr[6:0];
  assign f3        = instr[14:12];
  assign f7        = instr[31:25];
  assign imem_addr = pc;
  assign pc_plus4  = pc + XLEN'(4);

  // jalr clears bit 0 of the computed target; adds wrap modulo 2^XLEN.
  assign w_jalr_target  = alu_result & ~XLEN'(1);

  // Next-PC select: jalr target beats branch target beats sequential.
  always_comb begin
    w_next_pc = pc_plus4;
    if (pc_source2) begin
      w_next_pc = w_jalr_target;
    end else if (!pc_source1) begin
      w_next_pc = pc + imm_ext;
    end
  end

  assign w_next_aligned = (w_next_pc[1:0] == 2'b00);

  // Sequencer: state, PC, instruction latch, trap and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_BOOT;
      pc          <= XLEN'(RESET_PC);
      instr       <= c_nop;
      misaligned  <= 1'b0;
      bad_addr    <= '0;
      instret     <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state  <= S_FETCH;
          imem_req <= 1'b1;
        end

        S_FETCH: begin
          // Request and address stay put until the memory answers.
          if (imem_ready) begin
            instr       <= imem_rdata;
            r_state     <= S_EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end

        S_EXEC: begin
          if (!hold) begin
            instr_valid <= 1'b0;
            if (w_next_aligned) begin
              pc       <= w_next_pc;
              instret  <= instret + 32'd1;
              r_state  <= S_FETCH;
              imem_req <= 1'b1;
            end else begin
              // Faulting instruction does not retire; pc keeps its address.
              misaligned <= 1'b1;
              bad_addr   <= w_next_pc;
              r_state    <= S_HALT;
              imem_req   <= 1'b0;
            end
          end
        end

        S_HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end

        default: begin
          r_state     <= S_BOOT;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ============================================================================
//  Module      : tb_ifetch_unit
//  Description : Scoreboard bench for ifetch_unit. Directed instruction
//                sequences push expected fetches and executions; monitors
//                pop and compare whenever the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        pc_source1 = 1'b1;
  logic        pc_source2 = 1'b0;
  logic [31:0] imm_ext    = 32'h0;
  logic [31:0] alu_result = 32'h0;
  logic        hold       = 1'b0;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned;
  logic [31:0] bad_addr;
  logic [31:0] instret;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } fexp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          cyc;
  } eexp_t;

  fexp_t fq[$];
  eexp_t eq[$];

  ifetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .pc_source1 (pc_source1),
    .pc_source2 (pc_source2),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
    .hold       (hold),
    .instr      (instr),
    .op         (op),
    .f3         (f3),
    .f7         (f7),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned),
    .bad_addr   (bad_addr),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  // Memory image: addi-style word whose immediate and f3 encode the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[11:0], 5'd0, a[4:2], 5'd1, 7'h13};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Fetch monitor: every accepted request is matched against the queue.
  int          fcnt = 0;
  logic [31:0] faddr;
  always @(negedge clk) begin
    if (rst) begin
      fcnt = 0;
    end else if (imem_req) begin
      fcnt++;
      if (fcnt == 1) faddr = imem_addr;
      else chk("fetch_addr_stable", imem_addr, faddr);
      if (imem_ready) begin
        if (fq.size() == 0) begin
          chk("unexpected_fetch", imem_addr, 32'hxxxx_xxxx);
        end else begin
          fexp_t e;
          e = fq.pop_front();
          chk("fetch_addr", imem_addr, e.addr);
          chk("fetch_cycles", fcnt, e.cyc);
        end
        fcnt = 0;
      end
    end
  end

  // Execute monitor: checks fields on entry, stability, and duration on exit.
  int          ecnt = 0;
  eexp_t       ecur;
  always @(negedge clk) begin
    if (rst) begin
      ecnt = 0;
    end else if (instr_valid) begin
      ecnt++;
      if (ecnt == 1) begin
        if (eq.size() == 0) begin
          chk("unexpected_exec", pc, 32'hxxxx_xxxx);
          ecur.pc = pc; ecur.instr = instr; ecur.cyc = 0;
        end else begin
          ecur = eq.pop_front();
          chk("exec_pc", pc, ecur.pc);
          chk("exec_instr", instr, ecur.instr);
          chk("exec_pc_plus4", pc_plus4, ecur.pc + 32'd4);
          chk("exec_op", {25'd0, op}, {25'd0, ecur.instr[6:0]});
          chk("exec_f3", {29'd0, f3}, {29'd0, ecur.instr[14:12]});
          chk("exec_f7", {25'd0, f7}, {25'd0, ecur.instr[31:25]});
        end
      end else begin
        chk("exec_pc_stable", pc, ecur.pc);
        chk("exec_instr_stable", instr, ecur.instr);
      end
    end else if (ecnt > 0) begin
      chk("exec_cycles", ecnt, ecur.cyc);
      ecnt = 0;
    end
  end

  // One instruction: fetch at exp_pc with 'waits' wait states, then execute
  // with 'holds' stall cycles under the given controller inputs.
  task automatic do_instr(input logic [31:0] exp_pc, input int waits, input int holds,
                          input logic s1, input logic s2,
                          input logic [31:0] imm, input logic [31:0] alu);
    fexp_t f;
    eexp_t e;
    int    n;
    f.addr = exp_pc; f.cyc = waits + 1;
    e.pc = exp_pc; e.instr = mem_word(exp_pc); e.cyc = holds + 1;
    fq.push_back(f);
    eq.push_back(e);
    pc_source1 = s1;
    pc_source2 = s2;
    imm_ext    = imm;
    alu_result = alu;
    hold       = (holds > 0);
    imem_ready = (waits == 0);
    n = 0;
    while (!imem_req && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("timeout_fetch", 32'd0, 32'd1);
    if (waits > 0) begin
      repeat (waits) begin @(posedge clk); #1; end
      imem_ready = 1'b1;
    end
    n = 0;
    while (!instr_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("timeout_exec", 32'd0, 32'd1);
    imem_ready = 1'b0;
    repeat (holds) begin @(posedge clk); #1; end
    hold = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    chk("rst_bad_addr", bad_addr, 32'h0);
    chk("rst_instret", instret, 32'h0);
    rst = 1'b0;
    chk("boot_idle", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    chk("boot_one_cycle", {31'd0, imem_req}, 32'd1);

    // Sequential stream 0,4,8 then instret
    do_instr(32'h00, 0, 0, 1'b1, 1'b0, 32'h0, 32'h0);
    do_instr(32'h04, 0, 0, 1'b1, 1'b0, 32'h0, 32'h0);
    do_instr(32'h08, 0, 0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("instret_3", instret, 32'd3);
    do_instr(32'h0C, 0, 0, 1'b1, 1'b0, 32'h0, 32'h0);
    // Taken backward branch 0x10 -> 0x08
    do_instr(32'h10, 0, 0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
    do_instr(32'h08, 0, 0, 1'b0, 1'b0, 32'h0000_0018, 32'h0);
    // jalr 0x20 -> 0x101 & ~1 = 0x100
    do_instr(32'h20, 0, 0, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0101);
    do_instr(32'h100, 0, 0, 1'b0, 1'b0, 32'hFFFF_FF14, 32'h0);
    do_instr(32'h14, 0, 0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0);
    // Not-taken branch at 0x10 -> 0x14
    do_instr(32'h10, 0, 0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0);
    chk("instret_10", instret, 32'd10);
    // Wait states and hold: single retirement
    do_instr(32'h14, 3, 2, 1'b0, 1'b0, 32'h0000_002C, 32'h0);
    chk("instret_11", instret, 32'd11);
    // Misaligned branch target 0x40+6
    do_instr(32'h40, 0, 0, 1'b0, 1'b0, 32'h0000_0006, 32'h0);
    chk("trap_misaligned", {31'd0, misaligned}, 32'd1);
    chk("trap_bad_addr", bad_addr, 32'h46);
    chk("trap_pc", pc, 32'h40);
    chk("trap_instret", instret, 32'd11);
    repeat (3) @(posedge clk);
    #1;
    chk("halt_imem_req", {31'd0, imem_req}, 32'd0);
    chk("halt_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_misaligned", {31'd0, misaligned}, 32'd1);

    // Reset clears the trap
    rst = 1'b1;
    #1;
    chk("rst2_misaligned", {31'd0, misaligned}, 32'd0);
    chk("rst2_bad_addr", bad_addr, 32'h0);
    chk("rst2_instret", instret, 32'h0);
    chk("rst2_pc", pc, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_instr(32'h00, 0, 0, 1'b0, 1'b0, 32'h0000_0030, 32'h0);

    // Reset in the 2nd cycle of a stalled fetch at 0x30
    chk("stall_addr", imem_addr, 32'h30);
    @(posedge clk); #1;
    chk("stall_still_fetch", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    imem_ready = 1'b1;
    #1;
    chk("abort_imem_req", {31'd0, imem_req}, 32'd0);
    chk("abort_pc", pc, 32'h0);
    chk("abort_instr", instr, 32'h0000_0013);
    chk("abort_instret", instret, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_boot_req", {31'd0, imem_req}, 32'd0);
    chk("abort_boot_valid", {31'd0, instr_valid}, 32'd0);
    do_instr(32'h00, 0, 0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("restart_pc", pc, 32'h04);
    chk("restart_instret", instret, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("fetch_queue_empty", fq.size(), 32'd0);
    chk("exec_queue_empty", eq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- PC register and instruction-fetch sequencer feeding the single-cycle controller and datapath; it sits directly upstream of the controller.
- Fetches one instruction from a variable-latency instruction memory, holds it stable for one execute cycle and exposes the op/f3/f7 fields.
- In the execute cycle it consumes pc_source1/pc_source2 from the controller to register the next PC.
- Adds misaligned-target trapping and a retired-instruction counter.

Parameters:
- XLEN, 32, PC/data width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  XLEN  fetch address; equals pc.
- imem_ready  in  1  memory has valid imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- pc_source1  in  1  from controller; 0 = take pc+imm_ext, 1 = pc+4.
- pc_source2  in  1  from controller; 1 = jalr target, overrides pc_source1.
- imm_ext  in  XLEN  sign-extended immediate from the immediate unit.
- alu_result  in  XLEN  ALU output (jalr target).
- hold  in  1  datapath stall; keeps the current instruction in execute.
- instr  out  32  latched instruction.
- op  out  7  instr[6:0].
- f3  out  3  instr[14:12].
- f7  out  7  instr[31:25].
- instr_valid  out  1  instruction is in execute; controller outputs are meaningful.
- pc  out  XLEN  PC of the current instruction.
- pc_plus4  out  XLEN  pc+4, for jal/jalr writeback.
- misaligned  out  1  sticky trap flag.
- bad_addr  out  XLEN  faulting target address.
- instret  out  32  retired-instruction count.

Behaviour:
- States: BOOT, FETCH, EXEC, HALT.
- Reset (asynchronous):
  - state=BOOT, pc=RESET_PC, instr=32'h0000_0013 (nop).
  - misaligned=0, bad_addr=0, instret=0.
  - imem_req=0, instr_valid=0.
  - Reset asserted in any state, including mid-fetch or mid-execute, aborts the operation immediately. A pending memory response is ignored.
- BOOT: outputs idle; on the first rising edge after rst deasserts, go to FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_ready is sampled high.
  - On an edge with imem_ready=1: instr<=imem_rdata, go to EXEC.
  - On an edge with imem_ready=0: stay in FETCH.
  - instr_valid=0.
  - Minimum FETCH duration is 1 cycle.
- EXEC:
  - instr_valid=1, imem_req=0. op/f3/f7/pc/pc_plus4 are stable for the whole state.
  - Next-PC selection, by priority:
    - pc_source2=1: {alu_result[XLEN-1:1],1'b0}.
    - else pc_source1=0: pc+imm_ext.
    - else pc+4.
  - All additions are modulo 2^XLEN and wrap silently.
  - Edge with hold=1: stay in EXEC; pc, instr and instret are unchanged.
  - Edge with hold=0 and next_pc[1:0]==2'b00: pc<=next_pc, instret<=instret+1 (wraps 32'hFFFF_FFFF to 0), go to FETCH.
  - Edge with hold=0 and next_pc[1:0]!=2'b00:
    - misaligned<=1, bad_addr<=next_pc.
    - pc is unchanged and keeps the faulting instruction's PC.
    - instret is not incremented.
    - Go to HALT.
- HALT: imem_req=0, instr_valid=0. Exit only via rst.
- Throughput: 2 cycles per instruction at zero memory wait and no hold; each memory wait cycle adds 1 cycle.
- Field outputs (op, f3, f7) are pure slices of the instr register and carry no extra latency.

Test Plan:
- Reset with RESET_PC=0, imem_ready tied 1, memory holding add/addi words, pc_source1=1 -> BOOT lasts 1 cycle; imem_addr sequence 0,4,8; instr_valid pulses every 2nd cycle; instret=3 after 3 EXEC cycles.
- Taken beq at pc=0x10 with imm_ext=0xFFFF_FFF8 and pc_source1=0 -> next imem_addr=0x08. Not taken (pc_source1=1) -> 0x14.
- jalr at pc=0x20 with pc_source2=1, pc_source1=0, alu_result=0x0000_0101 -> next imem_addr=0x100; pc_plus4=0x24 during EXEC.
- Branch with imm_ext=0x6 from pc=0x40 -> misaligned=1, bad_addr=0x46, pc stays 0x40, imem_req stays 0 afterward, instret unchanged; rst clears all of it.
- imem_ready low for 3 cycles, then high -> FETCH lasts 4 cycles with imem_addr stable; hold=1 for 2 EXEC cycles -> instr_valid high 3 cycles, single instret increment.
- rst asserted in the 2nd cycle of a stalled FETCH at pc=0x30 -> outputs reset immediately; after release, fetch restarts at RESET_PC and the late imem_ready/rdata is ignored.
